hp_bytequad: RTL and testbench



---
 rtl/tube_pkg.sv | 21 ++
 rtl/hp_byte.sv | 34 +++
 rtl/hp_bytequad.sv | 115 +++++++++++
 tb/tb_hp_bytequad.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared Tube definitions: channel indices, R3 FIFO depth and the reset data value.
package tube_pkg;

  localparam int NUM_CH   = 4;
  localparam int R1       = 0;
  localparam int R2       = 1;
  localparam int R3       = 2;
  localparam int R4       = 3;
  localparam int R3_DEPTH = 2;

  localparam logic [7:0] RESET_DATA = 8'h00;

  typedef logic [7:0] tube_byte_t;
  typedef logic [1:0] r3_count_t;

  // Capacity of R3 in the given mode (one-byte mode holds a single byte).
  function automatic r3_count_t r3_capacity(input logic one_byte);
    return one_byte ? r3_count_t'(1) : r3_count_t'(R3_DEPTH);
  endfunction

endpackage

// File: rtl/hp_byte.sv
// Single-byte host-to-parasite latch: one data register plus a valid flag.
module hp_byte
  import tube_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push_req,
  input  logic       pop_req,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       valid
);

  logic [7:0] data_reg;
  logic       valid_reg;

  // A pop of a full latch wins over a same-cycle push; the data register is
  // left untouched on pop so the parasite can re-read the last byte.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_reg  <= RESET_DATA;
      valid_reg <= 1'b0;
    end else if (pop_req && valid_reg) begin
      valid_reg <= 1'b0;
    end else if (push_req && !valid_reg) begin
      data_reg  <= din;
      valid_reg <= 1'b1;
    end
  end

  assign dout  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/hp_bytequad.sv
// Host-to-parasite Tube register quad: byte latches on R1/R2/R4, a two-entry FIFO on R3.
module hp_bytequad
  import tube_pkg::*;
(
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       h_we,
  input  logic [3:0] h_selectData,
  input  logic [7:0] h_data,
  input  logic       p_rd,
  input  logic [3:0] p_selectData,
  input  logic       one_byte_mode,
  output logic [7:0] p_data,
  output logic [3:0] p_data_available,
  output logic [3:0] h_full,
  output logic       p_zero_bytes_available
);

  logic [7:0] ch_data [NUM_CH];
  logic [3:0] ch_avail;
  logic [3:0] ch_full;

  // R3 state: entry 0 is always the head; entry 1 is the younger byte.
  logic [7:0] r3_mem_reg  [R3_DEPTH];
  logic [7:0] r3_mem_next [R3_DEPTH];
  r3_count_t  r3_count_reg, r3_count_next;
  logic       draining_reg, draining_next;
  logic       mode_reg;
  logic       r3_full, r3_avail, r3_push, r3_pop;
  r3_count_t  r3_wr_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      if (gi == R3) begin : g_fifo
        assign ch_data[gi]  = r3_mem_reg[0];
        assign ch_avail[gi] = r3_avail;
        assign ch_full[gi]  = r3_full;
      end else begin : g_latch
        logic valid;
        hp_byte u_byte (
          .clk      (h_phi2),
          .rst_b    (h_rst_b),
          .push_req (h_we & h_selectData[gi]),
          .pop_req  (p_rd & p_selectData[gi]),
          .din      (h_data),
          .dout     (ch_data[gi]),
          .valid    (valid)
        );
        assign ch_avail[gi] = valid;
        assign ch_full[gi]  = valid;
      end
    end
  endgenerate

  // Mode is sampled so a change only alters capacity/availability after an edge.
  assign r3_full  = (r3_count_reg >= r3_capacity(mode_reg));
  assign r3_avail = mode_reg ? (r3_count_reg != 2'd0)
                             : ((r3_count_reg == 2'd2) || (draining_reg && r3_count_reg != 2'd0));
  assign r3_push  = h_we & h_selectData[R3] & ~r3_full;
  assign r3_pop   = p_rd & p_selectData[R3] & r3_avail;
  assign r3_wr_idx = r3_count_reg - {1'b0, r3_pop};

  always_comb begin
    r3_mem_next   = r3_mem_reg;
    r3_count_next = r3_count_reg + {1'b0, r3_push} - {1'b0, r3_pop};
    draining_next = draining_reg;
    // Only shift when a younger byte exists, so an emptied FIFO keeps showing its last head.
    if (r3_pop && r3_count_reg == 2'd2) begin
      r3_mem_next[0] = r3_mem_reg[1];
    end
    if (r3_push) begin
      if (r3_wr_idx == 2'd0) begin
        r3_mem_next[0] = h_data;
      end else begin
        r3_mem_next[1] = h_data;
      end
    end
    if (r3_pop && r3_count_reg == 2'd2) begin
      draining_next = 1'b1;
    end else if (r3_count_next == 2'd0) begin
      draining_next = 1'b0;
    end
  end

  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r3_mem_reg[0] <= RESET_DATA;
      r3_mem_reg[1] <= RESET_DATA;
      r3_count_reg  <= 2'd0;
      draining_reg  <= 1'b0;
      mode_reg      <= 1'b0;
    end else begin
      r3_mem_reg    <= r3_mem_next;
      r3_count_reg  <= r3_count_next;
      draining_reg  <= draining_next;
      mode_reg      <= one_byte_mode;
    end
  end

  // Lowest selected channel wins; scanning downward lets the lowest overwrite last.
  always_comb begin
    p_data = RESET_DATA;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (p_selectData[i]) begin
        p_data = ch_data[i];
      end
    end
  end

  assign p_data_available       = ch_avail;
  assign h_full                 = ch_full;
  assign p_zero_bytes_available = (r3_count_reg == 2'd0);

endmodule

// File: tb/tb_hp_bytequad.sv
// Bench for hp_bytequad: directed literal scenarios plus random traffic against a queue-based model.
module tb_hp_bytequad;

  logic       h_phi2 = 1'b0;
  logic       h_rst_b = 1'b0;
  logic       h_we = 1'b0;
  logic [3:0] h_selectData = 4'h0;
  logic [7:0] h_data = 8'h00;
  logic       p_rd = 1'b0;
  logic [3:0] p_selectData = 4'h0;
  logic       one_byte_mode = 1'b0;
  logic [7:0] p_data;
  logic [3:0] p_data_available;
  logic [3:0] h_full;
  logic       p_zero_bytes_available;

  int checks = 0;
  int errors = 0;

  hp_bytequad dut (
    .h_phi2                 (h_phi2),
    .h_rst_b                (h_rst_b),
    .h_we                   (h_we),
    .h_selectData           (h_selectData),
    .h_data                 (h_data),
    .p_rd                   (p_rd),
    .p_selectData           (p_selectData),
    .one_byte_mode          (one_byte_mode),
    .p_data                 (p_data),
    .p_data_available       (p_data_available),
    .h_full                 (h_full),
    .p_zero_bytes_available (p_zero_bytes_available)
  );

  always #5 h_phi2 = ~h_phi2;

  // Reference model: plain arrays for the latches, a queue for R3.
  logic [7:0] m_data [4] = '{default: 8'h00};
  logic [3:0] m_valid = 4'h0;
  logic [7:0] mq [$];
  logic       m_drain = 1'b0;
  logic       m_mode = 1'b0;
  logic [7:0] m_last = 8'h00;

  function automatic logic [3:0] m_avail();
    logic [3:0] a;
    a = m_valid;
    if (m_mode) a[2] = (mq.size() != 0);
    else        a[2] = (mq.size() == 2) || (m_drain && mq.size() != 0);
    return a;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    f = m_valid;
    f[2] = (mq.size() >= (m_mode ? 1 : 2));
    return f;
  endfunction

  function automatic logic [7:0] m_head(input int ch);
    if (ch != 2) return m_data[ch];
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  function automatic logic [7:0] m_pdata(input logic [3:0] sel);
    for (int i = 0; i < 4; i++) if (sel[i]) return m_head(i);
    return 8'h00;
  endfunction

  always @(posedge h_phi2 or negedge h_rst_b) begin : model
    logic [3:0] av, fl, push, pop;
    if (!h_rst_b) begin
      m_valid = 4'h0;
      for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
      mq.delete();
      m_drain = 1'b0;
      m_mode  = 1'b0;
      m_last  = 8'h00;
    end else begin
      av   = m_avail();
      fl   = m_full();
      push = {4{h_we}} & h_selectData & ~fl;
      pop  = {4{p_rd}} & p_selectData & av;
      for (int i = 0; i < 4; i++) begin
        if (i != 2) begin
          if (pop[i]) m_valid[i] = 1'b0;
          if (push[i]) begin
            m_data[i]  = h_data;
            m_valid[i] = 1'b1;
          end
        end
      end
      if (pop[2]) begin
        if (mq.size() == 2) m_drain = 1'b1;
        m_last = mq.pop_front();
      end
      if (push[2]) mq.push_back(h_data);
      if (mq.size() == 0) m_drain = 1'b0;
      m_mode = one_byte_mode;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge h_phi2) begin
    check("p_data",  p_data, m_pdata(p_selectData));
    check("avail",   {4'h0, p_data_available}, {4'h0, m_avail()});
    check("h_full",  {4'h0, h_full}, {4'h0, m_full()});
    check("zero",    {7'h0, p_zero_bytes_available}, {7'h0, (mq.size() == 0)});
  end

  // Called at negedge+1: apply strobes for one edge, then drop them at the next negedge+1.
  task automatic step(input logic we, input logic [3:0] hs, input logic [7:0] hd,
                      input logic rd, input logic [3:0] ps);
    h_we = we; h_selectData = hs; h_data = hd; p_rd = rd; p_selectData = ps;
    @(negedge h_phi2); #1;
    h_we = 1'b0; p_rd = 1'b0;
  endtask

  task automatic pulse_reset();
    h_rst_b = 1'b0; #1; h_rst_b = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge h_phi2); #1;
    check("rst_avail", {4'h0, p_data_available}, 8'h00);
    check("rst_zero",  {7'h0, p_zero_bytes_available}, 8'h01);
    h_rst_b = 1'b1;

    // Async reset while R3 holds two bytes.
    step(1, 4'b0100, 8'h11, 0, 4'b0100);
    step(1, 4'b0100, 8'h22, 0, 4'b0100);
    check("pre_rst_full", {4'h0, h_full}, 8'h04);
    #1 h_rst_b = 1'b0; #1;
    check("arst_pdata", p_data, 8'h00);
    check("arst_avail", {4'h0, p_data_available}, 8'h00);
    check("arst_full",  {4'h0, h_full}, 8'h00);
    check("arst_zero",  {7'h0, p_zero_bytes_available}, 8'h01);
    h_rst_b = 1'b1;
    @(negedge h_phi2); #1;

    // R1: second write while full is dropped; read clears valid.
    step(1, 4'b0001, 8'hA5, 0, 4'b0001);
    check("r1_full", {4'h0, h_full}, 8'h01);
    step(1, 4'b0001, 8'h3C, 0, 4'b0001);
    check("r1_keep", p_data, 8'hA5);
    step(0, 4'b0000, 8'h00, 1, 4'b0001);
    check("r1_avail_after", {4'h0, p_data_available}, 8'h00);
    check("r1_hold", p_data, 8'hA5);

    // R3 two-byte mode fill and drain.
    pulse_reset();
    step(1, 4'b0100, 8'h11, 0, 4'b0100);
    check("r3_one_avail", {7'h0, p_data_available[2]}, 8'h00);
    check("r3_one_zero",  {7'h0, p_zero_bytes_available}, 8'h00);
    step(1, 4'b0100, 8'h22, 0, 4'b0100);
    check("r3_two_avail", {7'h0, p_data_available[2]}, 8'h01);
    check("r3_two_full",  {7'h0, h_full[2]}, 8'h01);
    check("r3_head1", p_data, 8'h11);
    step(0, 4'b0000, 8'h00, 1, 4'b0100);
    check("r3_drain_avail", {7'h0, p_data_available[2]}, 8'h01);
    check("r3_head2", p_data, 8'h22);
    step(0, 4'b0000, 8'h00, 1, 4'b0100);
    check("r3_empty", {7'h0, p_zero_bytes_available}, 8'h01);
    check("r3_empty_avail", {7'h0, p_data_available[2]}, 8'h00);

    // R3 push and pop together while draining at count 1.
    pulse_reset();
    step(1, 4'b0100, 8'h01, 0, 4'b0100);
    step(1, 4'b0100, 8'h02, 0, 4'b0100);
    step(0, 4'b0000, 8'h00, 1, 4'b0100);
    check("sim_pre_head", p_data, 8'h02);
    step(1, 4'b0100, 8'h33, 1, 4'b0100);
    check("sim_head", p_data, 8'h33);
    check("sim_avail", {7'h0, p_data_available[2]}, 8'h01);
    check("sim_count1", {6'h0, h_full[2], p_zero_bytes_available}, 8'h00);

    // R3 one-byte mode, then switch back with one byte held.
    pulse_reset();
    one_byte_mode = 1'b1;
    step(0, 4'b0000, 8'h00, 0, 4'b0100);
    step(1, 4'b0100, 8'h44, 0, 4'b0100);
    check("ob_full", {7'h0, h_full[2]}, 8'h01);
    check("ob_avail", {7'h0, p_data_available[2]}, 8'h01);
    step(1, 4'b0100, 8'h55, 0, 4'b0100);
    check("ob_drop", p_data, 8'h44);
    one_byte_mode = 1'b0;
    step(0, 4'b0000, 8'h00, 0, 4'b0100);
    check("ob_sw_avail", {7'h0, p_data_available[2]}, 8'h00);
    check("ob_sw_full",  {7'h0, h_full[2]}, 8'h00);

    // Mux priority.
    pulse_reset();
    step(1, 4'b0010, 8'h77, 0, 4'b0000);
    step(1, 4'b1000, 8'h88, 0, 4'b0000);
    p_selectData = 4'b1010; #1;
    check("mux_1010", p_data, 8'h77);
    p_selectData = 4'b1000; #1;
    check("mux_1000", p_data, 8'h88);
    p_selectData = 4'b0000; #1;
    check("mux_none", p_data, 8'h00);
    @(negedge h_phi2); #1;

    // Random traffic, checked every cycle by the compare process.
    pulse_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] hs;
      case ($urandom_range(0, 5))
        0: hs = 4'b0001;
        1: hs = 4'b0010;
        2, 3: hs = 4'b0100;
        4: hs = 4'b1000;
        default: hs = 4'b0000;
      endcase
      if ($urandom_range(0, 15) == 0) one_byte_mode = ~one_byte_mode;
      step(1'($urandom_range(0, 1)), hs, 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
